insa_trace_buffer: RTL and testbench

- Storage end of the INSA buffer interface that the ALU reads through its INSAFIRST, INSALAST, INSAACTIVE, RSTBUF and ENCRASH operators.
- Captures tagged 32-bit records from the commit path into a circular buffer.
- Answers the ALU's combinational key lookup with the oldest and newest matching records.
- Raises a sticky crash flag on overflow once crash mode has been enabled.

---
 rtl/insa_trace_buffer.sv | 126 ++++++++++++
 tb/tb_insa_trace_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/insa_trace_buffer.sv
// rtl/insa_trace_buffer.sv - circular trace buffer with oldest/newest key lookup and sticky crash flag
//
// Captures tagged records from the commit path into a DEPTH-entry ring.
// The ALU looks records up by key with no added latency.
// Ports:
//   clk_i, rst_ni                           clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o/wr_key_i/wr_data_i record write handshake
//   alu_read_index_i                        lookup key
//   alu_read_out_o / alu_read_out2_o        payload of oldest / newest matching entry
//   data_in_buffer_o, count_o               occupancy
//   rst_buf_i                               synchronous buffer clear
//   en_crash_i, crash_o                     crash-mode enable, sticky overflow flag
module insa_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int KEY_W     = 20,
   parameter int DATA_W    = 32,
   parameter int OVERWRITE = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_valid_i,
   output logic                       wr_ready_o,
   input  logic [KEY_W-1:0]           wr_key_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic [KEY_W-1:0]           alu_read_index_i,
   output logic [DATA_W-1:0]          alu_read_out_o,
   output logic [DATA_W-1:0]          alu_read_out2_o,
   output logic                       data_in_buffer_o,
   input  logic                       rst_buf_i,
   input  logic                       en_crash_i,
   output logic                       crash_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [KEY_W-1:0]  key_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              crash_q, crash_d;

   logic              full;
   logic              we;
   logic              overflow;
   logic [PTR_W-1:0]  oldest;
   logic [PTR_W-1:0]  idx_f, idx_l;

   assign full       = (count_q == FULL_CNT);
   assign wr_ready_o = ~rst_buf_i & ((OVERWRITE != 0) | ~full);
   assign we         = wr_valid_i & wr_ready_o;
   // A write attempt against a full buffer counts as overflow whether it evicts or stalls.
   assign overflow   = wr_valid_i & full & ~rst_buf_i;
   // When full the truncated count is zero, so the oldest slot is the one about to be overwritten.
   assign oldest     = wr_ptr_q - count_q[PTR_W-1:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      crash_d  = crash_q | (overflow & en_crash_i);
      if (rst_buf_i) begin
         wr_ptr_d = '0;
         count_d  = '0;
         valid_d  = '0;
      end else if (we) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         if (!full) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         crash_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         crash_q  <= crash_d;
      end
   end

   // Payload storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (we) begin
         key_q[wr_ptr_q]  <= wr_key_i;
         data_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Valid entries always lie inside the age window starting at the oldest slot.
   // Scanning youngest-to-oldest with last-match-wins yields the oldest match;
   // scanning oldest-to-youngest yields the newest match.
   always_comb begin
      alu_read_out_o  = '0;
      alu_read_out2_o = '0;
      idx_f           = '0;
      idx_l           = '0;
      for (int a = DEPTH - 1; a >= 0; a--) begin
         idx_f = oldest + PTR_W'(a);
         if (valid_q[idx_f] && key_q[idx_f] == alu_read_index_i) begin
            alu_read_out_o = data_q[idx_f];
         end
      end
      for (int a = 0; a < DEPTH; a++) begin
         idx_l = oldest + PTR_W'(a);
         if (valid_q[idx_l] && key_q[idx_l] == alu_read_index_i) begin
            alu_read_out2_o = data_q[idx_l];
         end
      end
   end

   assign data_in_buffer_o = (count_q != '0);
   assign count_o          = count_q;
   assign crash_o          = crash_q;

endmodule

// File: tb/tb_insa_trace_buffer.sv
// tb/tb_insa_trace_buffer.sv - self-checking bench for insa_trace_buffer
module tb_insa_trace_buffer;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst_n;
   logic        wr_valid, wr_valid_b;
   logic [19:0] key, idx;
   logic [31:0] data;
   logic        rst_buf, en_crash;

   logic        rdy_a, dib_a, crash_a;
   logic [31:0] out1_a, out2_a;
   logic [4:0]  cnt_a;
   logic        rdy_b, dib_b, crash_b;
   logic [31:0] out1_b, out2_b;
   logic [4:0]  cnt_b;

   insa_trace_buffer #(.DEPTH(DEPTH), .KEY_W(20), .DATA_W(32), .OVERWRITE(1)) u_ow (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_valid_i(wr_valid), .wr_ready_o(rdy_a), .wr_key_i(key), .wr_data_i(data),
      .alu_read_index_i(idx), .alu_read_out_o(out1_a), .alu_read_out2_o(out2_a),
      .data_in_buffer_o(dib_a), .rst_buf_i(rst_buf), .en_crash_i(en_crash),
      .crash_o(crash_a), .count_o(cnt_a)
   );

   insa_trace_buffer #(.DEPTH(DEPTH), .KEY_W(20), .DATA_W(32), .OVERWRITE(0)) u_bp (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_valid_i(wr_valid_b), .wr_ready_o(rdy_b), .wr_key_i(key), .wr_data_i(data),
      .alu_read_index_i(idx), .alu_read_out_o(out1_b), .alu_read_out2_o(out2_b),
      .data_in_buffer_o(dib_b), .rst_buf_i(rst_buf), .en_crash_i(en_crash),
      .crash_o(crash_b), .count_o(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: records ordered oldest first, at most DEPTH of them.
   typedef struct {
      logic [19:0] key;
      logic [31:0] data;
   } rec_t;
   rec_t q[$];
   logic m_crash = 1'b0;

   function automatic logic [31:0] m_first(input logic [19:0] k);
      foreach (q[i]) if (q[i].key == k) return q[i].data;
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_last(input logic [19:0] k);
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].key == k) return q[i].data;
      return 32'h0;
   endfunction

   task automatic model_step();
      rec_t r;
      if (!rst_n) begin
         q.delete();
         m_crash = 1'b0;
         return;
      end
      if (en_crash && wr_valid && !rst_buf && q.size() == DEPTH) m_crash = 1'b1;
      if (rst_buf) begin
         q.delete();
      end else if (wr_valid) begin
         if (q.size() == DEPTH) void'(q.pop_front());
         r.key  = key;
         r.data = data;
         q.push_back(r);
      end
   endtask

   task automatic check_model();
      chk("ready", 64'(rdy_a), 64'(!rst_buf));
      chk("out_oldest", 64'(out1_a), 64'(m_first(idx)));
      chk("out_newest", 64'(out2_a), 64'(m_last(idx)));
      chk("count", 64'(cnt_a), 64'(q.size()));
      chk("data_in_buffer", 64'(dib_a), 64'(q.size() != 0));
      chk("crash", 64'(crash_a), 64'(m_crash));
   endtask

   // One clock with the given inputs: compare mid-cycle, then advance model with the edge.
   task automatic cyc(input logic wv, input logic [19:0] k, input logic [31:0] d,
                      input logic rb, input logic [19:0] ix);
      wr_valid = wv; key = k; data = d; rst_buf = rb; idx = ix;
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic peek(input logic [19:0] ix);
      idx = ix;
      #1;
   endtask

   task automatic async_reset();
      wr_valid = 1'b0; wr_valid_b = 1'b0; rst_buf = 1'b0;
      #2 rst_n = 1'b0;
      q.delete();
      m_crash = 1'b0;
      #1;
      chk("async_count", 64'(cnt_a), 64'h0);
      chk("async_dib", 64'(dib_a), 64'h0);
      chk("async_crash", 64'(crash_a), 64'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        wv;
      logic [19:0] k;
      logic [31:0] d;
      logic        rb;
      logic [19:0] ix;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [4:0]  ec;
      logic        er;
   } vec_t;
   vec_t tbl[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 20'h1, 32'hA,  1'b0, 20'h1, 32'h0,  32'h0,  5'd0, 1'b1};
      tbl[1] = '{1'b1, 20'h2, 32'hB,  1'b0, 20'h1, 32'hA,  32'hA,  5'd1, 1'b1};
      tbl[2] = '{1'b1, 20'h1, 32'hC,  1'b0, 20'h1, 32'hA,  32'hA,  5'd2, 1'b1};
      tbl[3] = '{1'b0, 20'h0, 32'h0,  1'b0, 20'h1, 32'hA,  32'hC,  5'd3, 1'b1};
      tbl[4] = '{1'b0, 20'h0, 32'h0,  1'b0, 20'h3, 32'h0,  32'h0,  5'd3, 1'b1};
      tbl[5] = '{1'b1, 20'h5, 32'h50, 1'b0, 20'h2, 32'hB,  32'hB,  5'd3, 1'b1};
      tbl[6] = '{1'b1, 20'h5, 32'h55, 1'b1, 20'h5, 32'h50, 32'h50, 5'd4, 1'b0};
      tbl[7] = '{1'b0, 20'h0, 32'h0,  1'b0, 20'h5, 32'h0,  32'h0,  5'd0, 1'b1};

      rst_n = 1'b0; wr_valid = 1'b0; wr_valid_b = 1'b0; key = '0; data = '0;
      idx = '0; rst_buf = 1'b0; en_crash = 1'b0;
      #12;
      chk("reset_count", 64'(cnt_a), 64'h0);
      chk("reset_dib", 64'(dib_a), 64'h0);
      chk("reset_out1", 64'(out1_a), 64'h0);
      chk("reset_out2", 64'(out2_a), 64'h0);
      chk("reset_ready", 64'(rdy_a), 64'h1);
      chk("reset_crash", 64'(crash_a), 64'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic writes, lookups and clear-beats-write.
      for (int i = 0; i < 8; i++) begin
         wr_valid = tbl[i].wv; key = tbl[i].k; data = tbl[i].d;
         rst_buf = tbl[i].rb; idx = tbl[i].ix;
         @(negedge clk);
         chk($sformatf("tbl%0d_out1", i), 64'(out1_a), 64'(tbl[i].e1));
         chk($sformatf("tbl%0d_out2", i), 64'(out2_a), 64'(tbl[i].e2));
         chk($sformatf("tbl%0d_count", i), 64'(cnt_a), 64'(tbl[i].ec));
         chk($sformatf("tbl%0d_dib", i), 64'(dib_a), 64'(tbl[i].ec != 0));
         chk($sformatf("tbl%0d_ready", i), 64'(rdy_a), 64'(tbl[i].er));
         check_model();
         @(posedge clk);
         model_step();
         #1;
      end

      // Fill past capacity: key 0 is evicted, key 16 is newest.
      cyc(1'b0, 20'h0, 32'h0, 1'b1, 20'h0);
      for (int k = 0; k <= 16; k++) cyc(1'b1, 20'(k), 32'(k + 'h100), 1'b0, 20'(k));
      peek(20'h0);
      chk("evict_k0_out1", 64'(out1_a), 64'h0);
      chk("evict_k0_out2", 64'(out2_a), 64'h0);
      peek(20'h10);
      chk("evict_k16_out1", 64'(out1_a), 64'h110);
      chk("evict_k16_out2", 64'(out2_a), 64'h110);
      chk("evict_count", 64'(cnt_a), 64'd16);
      chk("evict_crash", 64'(crash_a), 64'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 3) != 0, 20'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 29) == 0, 20'($urandom_range(0, 7)));
      end

      // Crash flag rises one cycle after the 17th write and survives a buffer clear.
      async_reset();
      en_crash = 1'b1;
      for (int k = 0; k < 16; k++) cyc(1'b1, 20'(k), 32'(k + 'h100), 1'b0, 20'(k));
      chk("crash_before_ovf", 64'(crash_a), 64'h0);
      cyc(1'b1, 20'h10, 32'h110, 1'b0, 20'h10);
      chk("crash_after_ovf", 64'(crash_a), 64'h1);
      cyc(1'b0, 20'h0, 32'h0, 1'b1, 20'h0);
      chk("crash_after_rstbuf", 64'(crash_a), 64'h1);
      chk("count_after_rstbuf", 64'(cnt_a), 64'h0);
      for (int k = 0; k < 7; k++) cyc(1'b1, 20'(k + 'h40), 32'(k + 'h400), 1'b0, 20'h40);
      chk("pre_async_count", 64'(cnt_a), 64'd7);
      chk("pre_async_crash", 64'(crash_a), 64'h1);
      async_reset();
      cyc(1'b1, 20'h77, 32'h777, 1'b0, 20'h77);
      peek(20'h77);
      chk("post_reset_lookup", 64'(out1_a), 64'h777);
      chk("post_reset_slot0_data", 64'(u_ow.data_q[0]), 64'h777);
      chk("post_reset_slot0_key", 64'(u_ow.key_q[0]), 64'h77);
      cyc(1'b0, 20'h0, 32'h0, 1'b0, 20'h77);

      // Back-pressured instance: full buffer stalls writes, contents kept.
      en_crash = 1'b0;
      wr_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         wr_valid_b = 1'b1; key = 20'(k + 'h200); data = 32'(k + 'h300);
         @(posedge clk);
         #1;
      end
      wr_valid_b = 1'b0;
      #1;
      chk("bp_full_count", 64'(cnt_b), 64'd16);
      chk("bp_full_ready", 64'(rdy_b), 64'h0);
      chk("bp_crash_idle", 64'(crash_b), 64'h0);
      en_crash = 1'b1;
      wr_valid_b = 1'b1; key = 20'h999; data = 32'hDEAD;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold%0d_count", n), 64'(cnt_b), 64'd16);
         chk($sformatf("bp_hold%0d_ready", n), 64'(rdy_b), 64'h0);
      end
      wr_valid_b = 1'b0;
      chk("bp_crash", 64'(crash_b), 64'h1);
      peek(20'h200);
      chk("bp_oldest_out1", 64'(out1_b), 64'h300);
      chk("bp_oldest_out2", 64'(out2_b), 64'h300);
      peek(20'h20F);
      chk("bp_newest", 64'(out2_b), 64'h30F);
      peek(20'h999);
      chk("bp_stalled_out1", 64'(out1_b), 64'h0);
      chk("bp_stalled_out2", 64'(out2_b), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
